tbu_sched: RTL

//  Sequencer for the Viterbi traceback unit's circular survivor memory.

---
 rtl/tbu_sched_pkg.sv | 40 ++++
 rtl/tbu_sched_if.sv | 33 +++
 rtl/tbu_sched_out_merge.sv | 53 +++++
 rtl/tbu_sched.sv | 105 ++++++++++
 4 files changed

// File: rtl/tbu_sched_pkg.sv
// tbu_pkg: shared parameters and types for the traceback sequencer.
//   S          survivor memory depth in trellis stages (columns)
//   X_MIN      traceback stages before decoded bits are trusted
//   B          decoded bits emitted per traceback segment
//   K          number of traceback read engines
//   NUM_STATES trellis states of the decoder
//   col_dec()  descending column step that wraps 0 -> S-1
package tbu_pkg;

  localparam int S          = 120;
  localparam int X_MIN      = 30;
  localparam int B          = 30;
  localparam int K          = 2;
  localparam int NUM_STATES = 64;

  localparam int COL_W   = $clog2(S);
  localparam int ENG_W   = $clog2(K);
  localparam int FILL_W  = $clog2(X_MIN + B + 1);
  localparam int PHASE_W = $clog2(B);

  typedef logic [COL_W-1:0]   col_t;
  typedef logic [ENG_W-1:0]   eng_t;
  typedef logic [K-1:0]       eng_mask_t;
  typedef logic [FILL_W-1:0]  fill_t;
  typedef logic [PHASE_W-1:0] phase_t;

  // SEQ_FILL: memory not yet deep enough for a trusted traceback.
  // SEQ_RUN:  launching one segment every B stages.
  typedef enum logic {
    SEQ_FILL,
    SEQ_RUN
  } seq_state_t;

  // Explicit compare against zero keeps the wrap correct when S is not a
  // power of two.
  function automatic col_t col_dec(input col_t c);
    return (c == '0) ? col_t'(S - 1) : col_t'(c - col_t'(1));
  endfunction

endpackage

// File: rtl/tbu_sched_if.sv
// tbu_sched_if: bundle of the sequencer's stage, BRAM, engine and output
// signals.
//   slave  : seen from the sequencer (tbu_sched)
//   master : seen from the surrounding datapath / testbench
interface tbu_sched_if;
  import tbu_pkg::*;

  logic      valid_in;
  logic      wr_en;
  col_t      wr_col;
  eng_mask_t tb_start;
  col_t      tb_col;
  eng_mask_t tb_busy;
  eng_mask_t dec_valid;
  eng_mask_t dec_bit;
  eng_mask_t dec_ready;
  logic      valid_out;
  logic      vit_desc;
  logic      overrun;

  modport slave (
    input  valid_in, tb_busy, dec_valid, dec_bit,
    output wr_en, wr_col, tb_start, tb_col, dec_ready,
           valid_out, vit_desc, overrun
  );

  modport master (
    output valid_in, tb_busy, dec_valid, dec_bit,
    input  wr_en, wr_col, tb_start, tb_col, dec_ready,
           valid_out, vit_desc, overrun
  );

endinterface

// File: rtl/tbu_sched_out_merge.sv
// tbu_out_merge: merges the K engines' decoded bits into one in-order
// stream. Only the engine at 'head' is ready; after B accepted bits the
// head moves to the next engine in round-robin order.
//   clk, sys_rst  clock, synchronous active-high reset
//   dec_valid     per-engine bit valid
//   dec_bit       per-engine decoded bit
//   dec_ready     one-hot, combinational: engine at head is accepted
//   valid_out     registered: a bit was accepted last cycle
//   vit_desc      registered decoded bit (holds when nothing accepted)
module tbu_out_merge
  import tbu_pkg::*;
(
  input  logic      clk,
  input  logic      sys_rst,
  input  eng_mask_t dec_valid,
  input  eng_mask_t dec_bit,
  output eng_mask_t dec_ready,
  output logic      valid_out,
  output logic      vit_desc
);

  eng_t   head;
  phase_t bit_ctr;
  logic   accept;

  always_comb begin
    dec_ready = eng_mask_t'(1) << head;
    accept    = dec_valid[head];
  end

  // The segment boundary is counted here rather than signalled by the
  // engine, so a stalled older segment always blocks younger ones.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      head      <= '0;
      bit_ctr   <= '0;
      valid_out <= 1'b0;
      vit_desc  <= 1'b0;
    end else begin
      valid_out <= accept;
      if (accept) begin
        vit_desc <= dec_bit[head];
        if (bit_ctr == phase_t'(B - 1)) begin
          bit_ctr <= '0;
          head    <= (head == eng_t'(K - 1)) ? eng_t'(0) : eng_t'(head + eng_t'(1));
        end else begin
          bit_ctr <= phase_t'(bit_ctr + phase_t'(1));
        end
      end
    end
  end

endmodule

// File: rtl/tbu_sched.sv
// tbu_sched: sequencer for the Viterbi traceback survivor memory.
// Owns the descending write column, launches traceback segments on the K
// engines in round-robin order, and forwards their bits in order through
// tbu_out_merge.
//   clk      system clock
//   sys_rst  synchronous, active-high reset
//   bus      tbu_sched_if.slave: valid_in, wr_en/wr_col, tb_start/tb_col,
//            tb_busy, dec_valid/dec_bit/dec_ready, valid_out/vit_desc,
//            overrun
module tbu_sched
  import tbu_pkg::*;
(
  input  logic        clk,
  input  logic        sys_rst,
  tbu_sched_if.slave  bus
);

  seq_state_t state_q, state_d;
  fill_t      fill_q, fill_d;
  phase_t     phase_q, phase_d;
  eng_t       launch_idx;
  col_t       next_col;
  logic       launch_now;

  always_ff @(posedge clk) begin
    if (sys_rst) state_q <= SEQ_FILL;
    else         state_q <= state_d;
  end

  // A launch is due on the stage that brings the fill count to X_MIN+B,
  // then on every B-th stage after it.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    phase_d    = phase_q;
    launch_now = 1'b0;
    if (bus.valid_in) begin
      case (state_q)
        SEQ_FILL: begin
          fill_d = fill_t'(fill_q + fill_t'(1));
          if (fill_q == fill_t'(X_MIN + B - 1)) begin
            state_d    = SEQ_RUN;
            phase_d    = '0;
            launch_now = 1'b1;
          end
        end
        SEQ_RUN: begin
          if (phase_q == phase_t'(B - 1)) begin
            phase_d    = '0;
            launch_now = 1'b1;
          end else begin
            phase_d = phase_t'(phase_q + phase_t'(1));
          end
        end
        default: state_d = SEQ_FILL;
      endcase
    end
  end

  // A launch to a busy engine is dropped without advancing launch_idx, so
  // the round-robin order stays aligned with the output merge head.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      fill_q       <= '0;
      phase_q      <= '0;
      launch_idx   <= '0;
      next_col     <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_col   <= '0;
      bus.tb_start <= '0;
      bus.tb_col   <= '0;
      bus.overrun  <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      phase_q      <= phase_d;
      bus.wr_en    <= bus.valid_in;
      bus.tb_start <= '0;
      if (bus.valid_in) begin
        bus.wr_col <= next_col;
        next_col   <= col_dec(next_col);
      end
      if (launch_now) begin
        if (bus.tb_busy[launch_idx]) begin
          bus.overrun <= 1'b1;
        end else begin
          bus.tb_start <= eng_mask_t'(1) << launch_idx;
          bus.tb_col   <= next_col;
          launch_idx   <= (launch_idx == eng_t'(K - 1)) ? eng_t'(0)
                                                        : eng_t'(launch_idx + eng_t'(1));
        end
      end
    end
  end

  tbu_out_merge u_out_merge (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .dec_valid (bus.dec_valid),
    .dec_bit   (bus.dec_bit),
    .dec_ready (bus.dec_ready),
    .valid_out (bus.valid_out),
    .vit_desc  (bus.vit_desc)
  );

endmodule
